// File: rtl/ysyx_23060020_lsu.sv
// Load/store unit: one request in flight, word-aligned memory cycles,
// read-modify-write for byte/half stores, extended load data back to WBU.
module ysyx_23060020_lsu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            in_wen,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_err,
    output logic            mem_valid,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            wen_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            err_q;
    logic [XLEN-1:0] rword_q;

    logic            accept;
    logic            req_err;
    logic [XLEN-1:0] merged;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ld_data;

    assign accept = (state_q == StIdle) && in_valid;

    // Alignment / size legality of the incoming request
    always_comb begin
        req_err = 1'b0;
        unique case (in_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = in_addr[0];
            2'b10:   req_err = (in_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // State register and request/read-word capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            rword_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
                wen_q   <= in_wen;
                size_q  <= in_size;
                uns_q   <= in_unsigned;
                err_q   <= req_err;
            end
            if (state_q == StRd) begin
                rword_q <= mem_rdata;
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (req_err)                         state_d = StResp;
                    else if (in_wen && in_size == 2'b10) state_d = StWr;
                    else                                 state_d = StRd;
                end
            end
            StRd:    state_d = wen_q ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Store word: replace only the addressed lane(s) of the word read back
    always_comb begin
        merged = rword_q;
        unique case (size_q)
            2'b00: begin
                for (int i = 0; i < 4; i++) begin
                    if (addr_q[1:0] == 2'(i)) merged[8*i +: 8] = wdata_q[7:0];
                end
            end
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        shifted = rword_q >> {addr_q[1:0], 3'b000};
        ld_data = shifted;
        unique case (size_q)
            2'b00:   ld_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    // Outputs are decoded from state; memory bus is all-zero when idle
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StResp);
        out_err   = out_valid && err_q;
        out_rdata = (out_valid && !err_q && !wen_q) ? ld_data : '0;
        mem_valid = (state_q == StRd) || (state_q == StWr);
        mem_wen   = (state_q == StWr);
        mem_addr  = mem_valid ? {addr_q[XLEN-1:2], 2'b00} : '0;
        mem_wdata = mem_wen ? merged : '0;
    end

endmodule

// File: tb/tb_ysyx_23060020_lsu.sv
// Bench for the LSU: byte-level memory reference model, directed table plus random requests.
module tb_ysyx_23060020_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        in_wen = 1'b0;
    logic [1:0]  in_size = 2'b00;
    logic        in_unsigned = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_valid;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    ysyx_23060020_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_wen(in_wen), .in_size(in_size),
        .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_err(out_err),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder: 64 words at 0x80000000, single-cycle
    logic [31:0] mem [64];
    logic [7:0]  refb [256];
    int          nrd = 0, nwr = 0, bad_addr = 0, idle_bad = 0;
    logic [31:0] cur_word = '0;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_valid) begin
            if (mem_addr != cur_word) bad_addr <= bad_addr + 1;
            if (mem_wen) begin
                nwr <= nwr + 1;
                mem[mem_addr[7:2]] <= mem_wdata;
            end else begin
                nrd <= nrd + 1;
            end
        end else if (mem_wen || mem_addr != 0 || mem_wdata != 0) begin
            idle_bad <= idle_bad + 1;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        mem[idx] = v;
        for (int i = 0; i < 4; i++) refb[idx*4+i] = v[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] v;
        int base;
        base = int'(a[7:2]) * 4;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = refb[base+i];
        return v;
    endfunction

    // Reference: treats memory as bytes; applies store effects, returns expected response
    function automatic void model(input logic [31:0] a, input logic [31:0] wd, input logic w,
                                  input logic [1:0] sz, input logic u,
                                  output logic [31:0] rd, output logic e,
                                  output int lat, output int nr, output int nw);
        int n, off;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a[7:0]);
        e = (sz == 2'd3) || ((off % n) != 0);
        rd = '0;
        if (e) begin
            lat = 1; nr = 0; nw = 0;
        end else if (w) begin
            for (int i = 0; i < n; i++) refb[off+i] = wd[8*i +: 8];
            nr = (n < 4) ? 1 : 0;
            nw = 1;
            lat = (n < 4) ? 3 : 2;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(refb[off+i]) << (8*i));
            if (!u && n == 1 && v[7])  v = v | 32'hFFFFFF00;
            if (!u && n == 2 && v[15]) v = v | 32'hFFFF0000;
            rd = v; lat = 2; nr = 1; nw = 0;
        end
    endfunction

    task automatic do_req(input string name, input logic [31:0] a, input logic [31:0] wd,
                          input logic w, input logic [1:0] sz, input logic u, input int hold,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                          input int exp_nr, input int exp_nw);
        int r0, w0, lat;
        logic [31:0] held;
        @(negedge clk);
        cur_word = {a[31:2], 2'b00};
        in_valid = 1'b1; in_addr = a; in_wdata = wd; in_wen = w;
        in_size = sz; in_unsigned = u;
        chk({name, " in_ready idle"}, 32'(in_ready), 32'd1);
        r0 = nrd; w0 = nwr;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; they must be ignored
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_wen = ~w;
        in_size = 2'($urandom); in_unsigned = ~u;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " rdata"}, out_rdata, exp_rd);
        chk({name, " err"}, 32'(out_err), 32'(exp_err));
        held = out_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, " stall valid"}, 32'(out_valid), 32'd1);
            chk({name, " stall rdata"}, out_rdata, held);
            chk({name, " stall in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " valid drop"}, 32'(out_valid), 32'd0);
        chk({name, " in_ready back"}, 32'(in_ready), 32'd1);
        chk({name, " reads"}, 32'(nrd - r0), 32'(exp_nr));
        chk({name, " writes"}, 32'(nwr - w0), 32'(exp_nw));
        chk({name, " mem word"}, mem[a[7:2]], ref_word(a));
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        int          hold;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] mrd, a, wd;
        logic        merr, w, u;
        logic [1:0]  sz;
        int          mlat, mnr, mnw, r0, w0;

        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(4, 32'hDEADBEEF);
        preload(8, 32'h11223344);
        preload(12, 32'h55667788);

        vecs[0]  = '{"lw",     32'h80000010, 32'h0,        1'b0, 2'd2, 1'b0, 0, 32'hDEADBEEF, 1'b0, 2};
        vecs[1]  = '{"lb",     32'h80000013, 32'h0,        1'b0, 2'd0, 1'b0, 0, 32'hFFFFFFDE, 1'b0, 2};
        vecs[2]  = '{"lbu",    32'h80000013, 32'h0,        1'b0, 2'd0, 1'b1, 0, 32'h000000DE, 1'b0, 2};
        vecs[3]  = '{"lh",     32'h80000012, 32'h0,        1'b0, 2'd1, 1'b0, 0, 32'hFFFFDEAD, 1'b0, 2};
        vecs[4]  = '{"lhu",    32'h80000010, 32'h0,        1'b0, 2'd1, 1'b1, 0, 32'h0000BEEF, 1'b0, 2};
        vecs[5]  = '{"sb",     32'h80000021, 32'hFFFFFFAB, 1'b1, 2'd0, 1'b0, 0, 32'h0,        1'b0, 3};
        vecs[6]  = '{"sh",     32'h80000022, 32'h1234CAFE, 1'b1, 2'd1, 1'b0, 0, 32'h0,        1'b0, 3};
        vecs[7]  = '{"lw rmw", 32'h80000020, 32'h0,        1'b0, 2'd2, 1'b0, 0, 32'hCAFEAB44, 1'b0, 2};
        vecs[8]  = '{"sw",     32'h80000020, 32'h01020304, 1'b1, 2'd2, 1'b0, 0, 32'h0,        1'b0, 2};
        vecs[9]  = '{"lw bp",  32'h80000020, 32'h0,        1'b0, 2'd2, 1'b0, 5, 32'h01020304, 1'b0, 2};
        vecs[10] = '{"lw mis", 32'h80000002, 32'h0,        1'b0, 2'd2, 1'b0, 0, 32'h0,        1'b1, 1};
        vecs[11] = '{"lh mis", 32'h80000001, 32'h0,        1'b0, 2'd1, 1'b0, 0, 32'h0,        1'b1, 1};
        vecs[12] = '{"sz11",   32'h80000000, 32'h0,        1'b1, 2'd3, 1'b0, 2, 32'h0,        1'b1, 1};

        #23;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset mem_valid", 32'(mem_valid), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            model(vecs[i].addr, vecs[i].wdata, vecs[i].wen, vecs[i].size, vecs[i].uns,
                  mrd, merr, mlat, mnr, mnw);
            do_req(vecs[i].name, vecs[i].addr, vecs[i].wdata, vecs[i].wen, vecs[i].size,
                   vecs[i].uns, vecs[i].hold, vecs[i].rdata, vecs[i].err, vecs[i].lat,
                   mnr, mnw);
        end

        for (int k = 0; k < 60; k++) begin
            a  = 32'h80000000 | 32'($urandom_range(0, 255));
            wd = $urandom;
            w  = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            u  = 1'($urandom);
            model(a, wd, w, sz, u, mrd, merr, mlat, mnr, mnw);
            do_req("rand", a, wd, w, sz, u, $urandom_range(0, 3), mrd, merr, mlat, mnr, mnw);
        end

        // Async reset while the sub-word store is in its write cycle
        preload(12, 32'h55667788);
        @(negedge clk);
        cur_word = 32'h80000030;
        in_valid = 1'b1; in_addr = 32'h80000031; in_wdata = 32'h000000EE;
        in_wen = 1'b1; in_size = 2'd0; in_unsigned = 1'b0;
        r0 = nrd; w0 = nwr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst mid wr mem_wen", 32'(mem_wen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async in_ready", 32'(in_ready), 32'd1);
        chk("rst async out_valid", 32'(out_valid), 32'd0);
        chk("rst async out_rdata", out_rdata, 32'd0);
        chk("rst async out_err", 32'(out_err), 32'd0);
        chk("rst async mem_valid", 32'(mem_valid), 32'd0);
        chk("rst async mem_wen", 32'(mem_wen), 32'd0);
        chk("rst async mem_addr", mem_addr, 32'd0);
        chk("rst async mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst after in_ready", 32'(in_ready), 32'd1);
        chk("rst reads", 32'(nrd - r0), 32'd1);
        chk("rst writes", 32'(nwr - w0), 32'd0);
        chk("rst mem untouched", mem[12], 32'h55667788);

        model(32'h80000031, 32'h0, 1'b0, 2'd0, 1'b1, mrd, merr, mlat, mnr, mnw);
        do_req("post rst lbu", 32'h80000031, 32'h0, 1'b0, 2'd0, 1'b1, 0, mrd, merr, mlat,
               mnr, mnw);

        chk("mem_addr word", 32'(bad_addr), 32'd0);
        chk("idle bus zero", 32'(idle_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
